// File: rtl/ps2_mouse_pkg.sv
// Shared constants and FSM encoding for the PS/2 mouse path.
// INC_W is also used by the ps2_mouse_interface receiver.
package ps2_mouse_pkg;

  localparam int INC_W     = 9;
  localparam int DEF_H_RES = 640;
  localparam int DEF_V_RES = 480;
  localparam int DEF_POS_W = 10;

  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,
    IDLE     = 3'd1,
    ACK      = 3'd2,
    CALC     = 3'd3,
    COMMIT   = 3'd4,
    FAULT    = 3'd5
  } ctrl_state_t;

endpackage

// File: rtl/ps2_axis_clamp.sv
// One cursor axis: scaled signed increment applied to a position, clamped to 0..LIMIT-1.
// INVERT subtracts the increment (mouse Y up is screen Y down).
module ps2_axis_clamp
  import ps2_mouse_pkg::*;
#(
  parameter int LIMIT  = DEF_H_RES,
  parameter int POS_W  = DEF_POS_W,
  parameter bit INVERT = 1'b0
) (
  input  logic [POS_W-1:0] pos,
  input  logic [INC_W-1:0] inc,
  input  logic [1:0]       speed,
  output logic [POS_W-1:0] result
);

  // Four guard bits hold 1023 +/- 2048 without wrapping before the clamp.
  localparam int SW = POS_W + 4;
  localparam logic signed [SW-1:0] MAX_S = SW'(LIMIT - 1);
  localparam logic [POS_W-1:0]     MAX_P = POS_W'(LIMIT - 1);

  logic signed [SW-1:0] pos_ext_s;
  logic signed [SW-1:0] inc_ext_s;
  logic signed [SW-1:0] delta_s;
  logic signed [SW-1:0] sum_s;

  // Sign-extend, scale, add or subtract, then saturate.
  always_comb begin
    pos_ext_s = {{(SW-POS_W){1'b0}}, pos};
    inc_ext_s = {{(SW-INC_W){inc[INC_W-1]}}, inc};
    delta_s   = inc_ext_s <<< speed;
    if (INVERT) begin
      sum_s = pos_ext_s - delta_s;
    end else begin
      sum_s = pos_ext_s + delta_s;
    end
    if (sum_s[SW-1]) begin
      result = {POS_W{1'b0}};
    end else if (sum_s > MAX_S) begin
      result = MAX_P;
    end else begin
      result = sum_s[POS_W-1:0];
    end
  end

endmodule

// File: rtl/ps2_cursor_ctrl.sv
// Sequences the PS/2 mouse receiver (init, bounded retries, packet handshake)
// and maintains a clamped absolute cursor with button state for the paint datapath.
module ps2_cursor_ctrl
  import ps2_mouse_pkg::*;
#(
  parameter int H_RES       = DEF_H_RES,
  parameter int V_RES       = DEF_V_RES,
  parameter int POS_W       = DEF_POS_W,
  parameter int RST_CYCLES  = 16,
  parameter int MAX_RETRIES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_ready,
  input  logic [INC_W-1:0] x_increment,
  input  logic [INC_W-1:0] y_increment,
  input  logic             left_button,
  input  logic             right_button,
  input  logic             error_no_ack,
  output logic             read,
  output logic             mouse_reset,
  input  logic [1:0]       speed,
  input  logic             recenter,
  output logic [POS_W-1:0] cursor_x,
  output logic [POS_W-1:0] cursor_y,
  output logic             btn_left,
  output logic             btn_right,
  output logic             click,
  output logic             update,
  output logic             fault
);

  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int RTY_W = $clog2(MAX_RETRIES + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRIES);
  localparam logic [POS_W-1:0] CENTER_X  = POS_W'(H_RES / 2);
  localparam logic [POS_W-1:0] CENTER_Y  = POS_W'(V_RES / 2);

  ctrl_state_t      state_r;
  logic [CNT_W-1:0] hold_cnt_r;
  logic [RTY_W-1:0] retry_cnt_r;
  logic [INC_W-1:0] x_inc_r;
  logic [INC_W-1:0] y_inc_r;
  logic [1:0]       speed_r;
  logic             left_r;
  logic             right_r;
  logic [POS_W-1:0] calc_x_r;
  logic [POS_W-1:0] calc_y_r;
  logic             recenter_pend_r;
  logic [POS_W-1:0] next_x_s;
  logic [POS_W-1:0] next_y_s;

  ps2_axis_clamp #(
    .LIMIT (H_RES),
    .POS_W (POS_W),
    .INVERT(1'b0)
  ) u_clamp_x (
    .pos   (cursor_x),
    .inc   (x_inc_r),
    .speed (speed_r),
    .result(next_x_s)
  );

  ps2_axis_clamp #(
    .LIMIT (V_RES),
    .POS_W (POS_W),
    .INVERT(1'b1)
  ) u_clamp_y (
    .pos   (cursor_y),
    .inc   (y_inc_r),
    .speed (speed_r),
    .result(next_y_s)
  );

  // Controller FSM with registered handshake, cursor and status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r         <= RST_HOLD;
      hold_cnt_r      <= {CNT_W{1'b0}};
      retry_cnt_r     <= {RTY_W{1'b0}};
      x_inc_r         <= {INC_W{1'b0}};
      y_inc_r         <= {INC_W{1'b0}};
      speed_r         <= 2'd0;
      left_r          <= 1'b0;
      right_r         <= 1'b0;
      calc_x_r        <= CENTER_X;
      calc_y_r        <= CENTER_Y;
      recenter_pend_r <= 1'b0;
      mouse_reset     <= 1'b1;
      read            <= 1'b0;
      fault           <= 1'b0;
      cursor_x        <= CENTER_X;
      cursor_y        <= CENTER_Y;
      btn_left        <= 1'b0;
      btn_right       <= 1'b0;
      click           <= 1'b0;
      update          <= 1'b0;
    end else begin
      read   <= 1'b0;
      click  <= 1'b0;
      update <= 1'b0;
      case (state_r)
        RST_HOLD: begin
          mouse_reset <= 1'b1;
          if (hold_cnt_r == HOLD_LAST) begin
            hold_cnt_r  <= {CNT_W{1'b0}};
            mouse_reset <= 1'b0;
            state_r     <= IDLE;
          end else begin
            hold_cnt_r <= hold_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        IDLE: begin
          // A missing ack outranks a pending packet: the link is suspect.
          if (error_no_ack) begin
            mouse_reset <= 1'b1;
            if (retry_cnt_r < RTY_MAX) begin
              retry_cnt_r <= retry_cnt_r + {{(RTY_W-1){1'b0}}, 1'b1};
              state_r     <= RST_HOLD;
            end else begin
              fault   <= 1'b1;
              state_r <= FAULT;
            end
          end else if (data_ready) begin
            read    <= 1'b1;
            state_r <= ACK;
          end else begin
            state_r <= IDLE;
          end
          if (recenter) begin
            cursor_x <= CENTER_X;
            cursor_y <= CENTER_Y;
            update   <= 1'b1;
          end
        end
        ACK: begin
          x_inc_r     <= x_increment;
          y_inc_r     <= y_increment;
          speed_r     <= speed;
          left_r      <= left_button;
          right_r     <= right_button;
          retry_cnt_r <= {RTY_W{1'b0}};
          if (recenter) begin
            recenter_pend_r <= 1'b1;
          end
          state_r <= CALC;
        end
        CALC: begin
          calc_x_r <= next_x_s;
          calc_y_r <= next_y_s;
          if (recenter) begin
            recenter_pend_r <= 1'b1;
          end
          state_r <= COMMIT;
        end
        COMMIT: begin
          // A recenter seen during the packet overrides the position, one update total.
          if (recenter || recenter_pend_r) begin
            cursor_x <= CENTER_X;
            cursor_y <= CENTER_Y;
          end else begin
            cursor_x <= calc_x_r;
            cursor_y <= calc_y_r;
          end
          btn_left        <= left_r;
          btn_right       <= right_r;
          click           <= left_r & ~btn_left;
          update          <= 1'b1;
          recenter_pend_r <= 1'b0;
          state_r         <= IDLE;
        end
        FAULT: begin
          mouse_reset <= 1'b1;
          fault       <= 1'b1;
          state_r     <= FAULT;
        end
        default: begin
          mouse_reset <= 1'b1;
          hold_cnt_r  <= {CNT_W{1'b0}};
          state_r     <= RST_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_cursor_ctrl.sv
// Self-checking bench for ps2_cursor_ctrl: vector table of packets with a
// scoreboard queue popped on update, plus init/retry/fault/recenter sequences.
module tb_ps2_cursor_ctrl;

  typedef struct {
    logic [8:0] xi;
    logic [8:0] yi;
    logic [1:0] spd;
    logic       l;
    logic       r;
    logic [9:0] ex;
    logic [9:0] ey;
    logic       el;
    logic       er;
    logic       ec;
  } vec_t;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       l;
    logic       r;
    logic       c;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       data_ready = 1'b0;
  logic [8:0] x_increment = 9'd0;
  logic [8:0] y_increment = 9'd0;
  logic       left_button = 1'b0;
  logic       right_button = 1'b0;
  logic       error_no_ack = 1'b0;
  logic       read;
  logic       mouse_reset;
  logic [1:0] speed = 2'd0;
  logic       recenter = 1'b0;
  logic [9:0] cursor_x;
  logic [9:0] cursor_y;
  logic       btn_left;
  logic       btn_right;
  logic       click;
  logic       update;
  logic       fault;

  int   total = 0;
  int   bad = 0;
  int   read_cnt = 0;
  exp_t sb_q[$];
  vec_t vec[11];

  ps2_cursor_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .data_ready  (data_ready),
    .x_increment (x_increment),
    .y_increment (y_increment),
    .left_button (left_button),
    .right_button(right_button),
    .error_no_ack(error_no_ack),
    .read        (read),
    .mouse_reset (mouse_reset),
    .speed       (speed),
    .recenter    (recenter),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .click       (click),
    .update      (update),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: count reads, pop the scoreboard on every update.
  always @(negedge clk) begin
    exp_t e;
    if (read === 1'b1) begin
      read_cnt++;
      chk("read_while_mouse_reset", {31'd0, mouse_reset}, 32'd0);
    end
    if (update === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_update", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("cursor_x", {22'd0, cursor_x}, {22'd0, e.x});
        chk("cursor_y", {22'd0, cursor_y}, {22'd0, e.y});
        chk("btn_left", {31'd0, btn_left}, {31'd0, e.l});
        chk("btn_right", {31'd0, btn_right}, {31'd0, e.r});
        chk("click", {31'd0, click}, {31'd0, e.c});
      end
    end
  end

  task automatic count_high(output int n);
    n = 0;
    while (mouse_reset === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Drive one packet from IDLE and check the read/update timing around it.
  task automatic send_pkt(input vec_t v, input logic rc_in_calc);
    exp_t e;
    int   rd0;
    x_increment  = v.xi;
    y_increment  = v.yi;
    speed        = v.spd;
    left_button  = v.l;
    right_button = v.r;
    data_ready   = 1'b1;
    e = '{v.ex, v.ey, v.el, v.er, v.ec};
    sb_q.push_back(e);
    rd0 = read_cnt;
    @(negedge clk);
    chk("read_latency", {31'd0, read}, 32'd1);
    @(negedge clk);
    chk("read_single_cycle", {31'd0, read}, 32'd0);
    data_ready = 1'b0;
    recenter   = rc_in_calc;
    @(negedge clk);
    recenter = 1'b0;
    chk("update_early", {31'd0, update}, 32'd0);
    @(negedge clk);
    chk("update_latency", {31'd0, update}, 32'd1);
    @(negedge clk);
    chk("update_single_cycle", {31'd0, update}, 32'd0);
    chk("reads_per_packet", read_cnt - rd0, 32'd1);
    chk("sb_drained", sb_q.size(), 32'd0);
  endtask

  initial begin
    int   n;
    int   rd0;
    vec_t v;
    exp_t e;

    // xi, yi, spd, l, r, expected x, y, btn_left, btn_right, click; chained from (320,240)
    vec[0]  = '{9'h100, 9'h000, 2'd0, 1'b0, 1'b0, 10'd64,  10'd240, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{9'h100, 9'h000, 2'd0, 1'b0, 1'b0, 10'd0,   10'd240, 1'b0, 1'b0, 1'b0};
    vec[2]  = '{9'h000, 9'h0FF, 2'd3, 1'b0, 1'b0, 10'd0,   10'd0,   1'b0, 1'b0, 1'b0};
    vec[3]  = '{9'h0FF, 9'h000, 2'd2, 1'b0, 1'b0, 10'd639, 10'd0,   1'b0, 1'b0, 1'b0};
    vec[4]  = '{9'h1FF, 9'h1FF, 2'd0, 1'b1, 1'b0, 10'd638, 10'd1,   1'b1, 1'b0, 1'b1};
    vec[5]  = '{9'h000, 9'h000, 2'd0, 1'b1, 1'b1, 10'd638, 10'd1,   1'b1, 1'b1, 1'b0};
    vec[6]  = '{9'h002, 9'h000, 2'd1, 1'b0, 1'b0, 10'd639, 10'd1,   1'b0, 1'b0, 1'b0};
    vec[7]  = '{9'h1F6, 9'h100, 2'd1, 1'b0, 1'b0, 10'd619, 10'd479, 1'b0, 1'b0, 1'b0};
    vec[8]  = '{9'h000, 9'h001, 2'd0, 1'b1, 1'b0, 10'd619, 10'd478, 1'b1, 1'b0, 1'b1};
    vec[9]  = '{9'h0FF, 9'h0FF, 2'd3, 1'b0, 1'b0, 10'd639, 10'd0,   1'b0, 1'b0, 1'b0};
    vec[10] = '{9'h100, 9'h100, 2'd3, 1'b0, 1'b0, 10'd0,   10'd479, 1'b0, 1'b0, 1'b0};

    // Reset state, then the initial receiver hold.
    repeat (3) @(negedge clk);
    chk("rst_mouse_reset", {31'd0, mouse_reset}, 32'd1);
    chk("rst_cursor_x", {22'd0, cursor_x}, 32'd320);
    chk("rst_cursor_y", {22'd0, cursor_y}, 32'd240);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_update", {31'd0, update}, 32'd0);
    chk("rst_read", {31'd0, read}, 32'd0);
    chk("rst_click", {31'd0, click}, 32'd0);
    reset = 1'b1;
    count_high(n);
    chk("init_hold_len", n, 32'd16);

    // First packet, then recenter in IDLE.
    v = '{9'h00A, 9'h005, 2'd0, 1'b0, 1'b0, 10'd330, 10'd235, 1'b0, 1'b0, 1'b0};
    send_pkt(v, 1'b0);
    e = '{10'd320, 10'd240, 1'b0, 1'b0, 1'b0};
    sb_q.push_back(e);
    recenter = 1'b1;
    @(negedge clk);
    recenter = 1'b0;
    chk("recenter_update", {31'd0, update}, 32'd1);
    @(negedge clk);
    chk("recenter_sb_drained", sb_q.size(), 32'd0);

    foreach (vec[i]) send_pkt(vec[i], 1'b0);

    // Recenter while the packet is in CALC: centre wins, buttons commit, one update.
    v = '{9'h010, 9'h010, 2'd0, 1'b0, 1'b1, 10'd320, 10'd240, 1'b0, 1'b1, 1'b0};
    send_pkt(v, 1'b1);
    repeat (3) @(negedge clk);

    // Error and data in the same IDLE cycle: re-init, no read; then retries into FAULT.
    rd0          = read_cnt;
    error_no_ack = 1'b1;
    data_ready   = 1'b1;
    @(negedge clk);
    chk("err_prio_no_read", {31'd0, read}, 32'd0);
    chk("err_prio_mouse_reset", {31'd0, mouse_reset}, 32'd1);
    data_ready = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      count_high(n);
      chk($sformatf("retry_hold_len_%0d", p), n, 32'd16);
      chk($sformatf("retry_gap_%0d", p), {31'd0, mouse_reset}, 32'd0);
      chk($sformatf("retry_no_fault_%0d", p), {31'd0, fault}, 32'd0);
      @(negedge clk);
    end
    chk("fault_set", {31'd0, fault}, 32'd1);
    chk("fault_mouse_reset", {31'd0, mouse_reset}, 32'd1);
    data_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("fault_sticky", {31'd0, fault}, 32'd1);
    chk("fault_mouse_reset_stuck", {31'd0, mouse_reset}, 32'd1);
    chk("fault_no_reads", read_cnt - rd0, 32'd0);
    data_ready   = 1'b0;
    error_no_ack = 1'b0;

    // Controller reset clears the fault and re-initialises the receiver.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reclear_fault", {31'd0, fault}, 32'd0);
    chk("reclear_mouse_reset", {31'd0, mouse_reset}, 32'd1);
    chk("reclear_cursor_x", {22'd0, cursor_x}, 32'd320);
    chk("reclear_cursor_y", {22'd0, cursor_y}, 32'd240);
    chk("reclear_btn_right", {31'd0, btn_right}, 32'd0);
    reset = 1'b1;
    count_high(n);
    chk("reinit_hold_len", n, 32'd16);
    chk("final_sb_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
